// File: rtl/mult_div_unit.sv
// mult_div_unit -- iterative 32-bit multiply/divide unit feeding HI/LO.
//
// Build option: define MDU_DIV_EN to include the restoring divider
// (DIVU/DIV). Without it, op 2/3 requests are dropped in IDLE and
// div_zero is held at 0.
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   start, op         request; op 0 MULTU, 1 MULT, 2 DIVU, 3 DIV
//   operand_a/_b      rs / rt values, captured only on an accepted start
//   mthi, mtlo, wdata direct HI/LO writes, honoured only in IDLE
//   hi, lo            result registers
//   busy              operation in flight (state-decoded only)
//   done              one-cycle pulse after HI/LO take a result
//   div_zero          pulses with done when a divide had operand_b == 0
//
// state | meaning
// IDLE  | accept start / MTHI / MTLO
// CALC  | one shift-add or shift-subtract iteration per cycle, 32 cycles
// FIX   | sign correction, write HI/LO, raise done
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   src_q, src_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;     // {partial product | multiplier} or {remainder | quotient}
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next, prod;

`ifdef MDU_DIV_EN
  logic               is_div_q, is_div_d;
  logic               rem_neg_q, rem_neg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH:0]     rem_sh, diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quot, rem;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    a_neg = op[0] & operand_a[WIDTH-1];
    b_neg = op[0] & operand_b[WIDTH-1];
    a_mag = a_neg ? -operand_a : operand_a;
    b_mag = b_neg ? -operand_b : operand_b;

    // Shift-add: add multiplicand to the upper half when the multiplier LSB
    // is set, then shift the whole accumulator right including the carry.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, src_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    prod     = neg_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
    accept     = 1'b1;
    is_div_d   = is_div_q;
    rem_neg_d  = rem_neg_q;
    dz_d       = dz_q;
    a_raw_d    = a_raw_q;
    div_zero_d = 1'b0;

    // Restoring divide: shift the next dividend bit into the remainder and
    // keep the difference only when it does not borrow.
    rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, src_q};
    if (!diff[WIDTH])
      div_next = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      div_next = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    quot = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem  = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`else
    accept = ~op[1];
`endif

    case (state_q)
      IDLE: begin
        if (mthi) hi_d = wdata;
        if (mtlo) lo_d = wdata;
        if (start && accept) begin
          state_d = CALC;
          cnt_d   = '0;
          neg_d   = a_neg ^ b_neg;
`ifdef MDU_DIV_EN
          is_div_d  = op[1];
          rem_neg_d = a_neg;
          dz_d      = (operand_b == '0);
          a_raw_d   = operand_a;
          src_d     = op[1] ? b_mag : a_mag;
          acc_d     = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
`else
          src_d = a_mag;
          acc_d = {{WIDTH{1'b0}}, b_mag};
`endif
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
`ifdef MDU_DIV_EN
        acc_d = is_div_q ? div_next : mul_next;
`else
        acc_d = mul_next;
`endif
        if (cnt_q == 5'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          div_zero_d = dz_q;
          if (dz_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
`else
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

`ifdef MDU_DIV_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      is_div_q   <= 1'b0;
      rem_neg_q  <= 1'b0;
      dz_q       <= 1'b0;
      a_raw_q    <= '0;
      div_zero_q <= 1'b0;
    end else begin
      is_div_q   <= is_div_d;
      rem_neg_q  <= rem_neg_d;
      dz_q       <= dz_d;
      a_raw_q    <= a_raw_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: the stimulus process queues the
// expected HI/LO/div_zero for every operation it starts, and a monitor
// pops and compares whenever done is seen.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   done_seen = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  // Monitor: compare every done pulse against the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (!reset && done) begin
      done_seen++;
      chk("done_width", {31'd0, done_prev}, 32'd0);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 hi=%h lo=%h required no pending op", hi, lo);
      end else begin
        e = exp_q.pop_front();
        chk({e.nm, "_hi"}, hi, e.hi);
        chk({e.nm, "_lo"}, lo, e.lo);
        chk({e.nm, "_div_zero"}, {31'd0, div_zero}, {31'd0, e.dz});
      end
    end
    done_prev = reset ? 1'b0 : done;
  end

  // Issue one operation and measure how long busy stays high. With now=1 the
  // start is raised immediately (used to start in the done cycle).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input logic edz,
                        input string nm, input bit now);
    exp_t e;
    int   n;
    e.nm = nm; e.hi = eh; e.lo = el; e.dz = edz;
    exp_q.push_back(e);
    if (!now) begin
      @(posedge clock); #1;
    end
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clock); #1;
    start = 1'b0; op = ~o; operand_a = 32'hDEAD_BEEF; operand_b = 32'h1234_5678;
    n = 0;
    while (busy && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk({nm, "_busy_len"}, n, 32'd33);
  endtask

  task automatic write_hilo(input logic h, input logic l, input logic [31:0] d);
    @(posedge clock); #1;
    mthi = h; mtlo = l; wdata = d;
    @(posedge clock); #1;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'h0;
  endtask

  initial begin
    int n;
    int done_before;
    reset = 1'b1; start = 1'b0; op = 2'd0; operand_a = 32'h0; operand_b = 32'h0;
    mthi = 1'b0; mtlo = 1'b0; wdata = 32'h0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_div_zero", {31'd0, div_zero}, 32'd0);
    reset = 1'b0;

    write_hilo(1'b1, 1'b0, 32'hCAFE_0001);
    chk("mthi_latency", hi, 32'hCAFE_0001);
    write_hilo(1'b0, 1'b1, 32'hCAFE_0002);
    chk("mtlo_latency", lo, 32'hCAFE_0002);
    chk("mtlo_keeps_hi", hi, 32'hCAFE_0001);

    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max", 1'b0);
    run_op(2'd1, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg", 1'b0);
    run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult_b2b", 1'b1);
    run_op(2'd0, 32'd12345, 32'd1000, 32'h0, 32'h00BC_5EA8, 1'b0, "multu_small", 1'b0);

`ifdef MDU_DIV_EN
    run_op(2'd3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_neg", 1'b0);
    run_op(2'd2, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, "divu_zero", 1'b0);
    run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, "div_ovf", 1'b0);
    run_op(2'd2, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "divu_plain", 1'b0);
    run_op(2'd3, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, "div_negb", 1'b0);
    run_op(2'd3, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "div_zero_s", 1'b0);
`else
    // Divider absent: a divide request must leave the unit idle and HI/LO intact.
    write_hilo(1'b1, 1'b1, 32'h0000_1111);
    @(posedge clock); #1;
    start = 1'b1; op = 2'd2; operand_a = 32'd100; operand_b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    chk("nodiv_busy", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    start = 1'b1; op = 2'd3;
    @(posedge clock); #1;
    start = 1'b0;
    chk("nodiv_busy_s", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge clock);
    #1;
    chk("nodiv_hi", hi, 32'h0000_1111);
    chk("nodiv_lo", lo, 32'h0000_1111);
`endif

    // Interference: MTHI and a second start at cycle 10 of a MULTU are dropped.
    write_hilo(1'b1, 1'b0, 32'h0BAD_F00D);
    begin
      exp_t e;
      e.nm = "interf"; e.hi = 32'h0; e.lo = 32'd30; e.dz = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    start = 1'b1; op = 2'd0; operand_a = 32'd5; operand_b = 32'd6;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clock); #1;
    end
    mthi = 1'b1; wdata = 32'hAAAA_5555; start = 1'b1; operand_a = 32'd1; operand_b = 32'd1;
    @(posedge clock); #1;
    mthi = 1'b0; start = 1'b0;
    chk("interf_mthi_ignored", hi, 32'h0BAD_F00D);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clock); #1;
      n++;
    end
    chk("interf_busy_rest", n, 32'd23);
    repeat (40) @(posedge clock);
    #1;

    // Reset 20 cycles into an operation: immediate clear, no done afterwards.
    write_hilo(1'b1, 1'b0, 32'h0000_0077);
    done_before = done_seen;
    @(posedge clock); #1;
    start = 1'b1; op = 2'd0; operand_a = 32'd5; operand_b = 32'd6;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (19) begin
      @(posedge clock); #1;
    end
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    repeat (45) @(posedge clock);
    #1;
    chk("midrst_no_done", done_seen, done_before);
    chk("midrst_hi_after", hi, 32'h0);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit for the single-cycle MIPS core, sitting directly downstream of the register-file decode stage. It consumes the two register read operands (rs, rt) of MULT/MULTU/DIV/DIVU and produces the HI/LO pair read back by MFHI/MFLO. MTHI/MTLO load HI/LO directly. Operations take multiple cycles; `busy` tells the controller to stall.

## Interface
- `WIDTH`, 32, operand and HI/LO width; only 32 is supported.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request an operation; sampled only in IDLE.
- `op`  in  2  operation: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV.
- `operand_a`  in  32  rs value (multiplicand / dividend).
- `operand_b`  in  32  rt value (multiplier / divisor).
- `mthi`  in  1  write `wdata` to HI (MTHI).
- `mtlo`  in  1  write `wdata` to LO (MTLO).
- `wdata`  in  32  MTHI/MTLO data (rs value).
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `busy`  out  1  operation in progress; the controller must stall.
- `done`  out  1  one-cycle pulse in the cycle after HI/LO take the result.
- `div_zero`  out  1  pulses together with `done` when a divide had `operand_b == 0`.

## Operation
- States:
  - IDLE:
    - A sampled `start` latches `op`, the operand magnitudes, and the result-sign flags.
    - It clears the 5-bit iteration counter and moves to CALC.
  - CALC:
    - Performs one iteration per cycle: shift-add for multiply, restoring shift-subtract for divide.
    - After the 32nd iteration (counter == 31) it moves to FIX.
  - FIX:
    - Applies sign correction and writes HI/LO.
    - Moves to IDLE.
- Signed ops (MULT, DIV):
  - Operate on absolute values.
  - MULT product is negated when `a[31]^b[31]`.
  - DIV quotient is negated when `a[31]^b[31]`; DIV remainder takes the sign of `a`.
- Multiply result: HI = product[63:32], LO = product[31:0].
- Divide result: LO = quotient, HI = remainder.
- Divide by zero:
  - Runs the normal timing.
  - Forced result: LO = 32'hFFFF_FFFF, HI = original `operand_a`, with `div_zero` = 1.
- Signed overflow: DIV of 32'h8000_0000 by 32'hFFFF_FFFF gives LO = 32'h8000_0000, HI = 0.
- MTHI/MTLO:
  - Take effect only in IDLE and are ignored while busy.
  - If `mthi`/`mtlo` and `start` occur in the same IDLE cycle, the write happens and the operation starts. The later FIX overwrites both registers.
- `start` while not IDLE is ignored; there is no queueing.
- `op` or operand changes after the start cycle have no effect.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_zero` = 0. State is IDLE and the counter is 0.
- Reset mid-operation aborts immediately to these values. No partial result is written.
- Start accepted at edge E0:
  - `busy` is 1 from after E0 through E33.
  - CALC occupies edges E1..E32; HI/LO update at edge E33 (FIX).
- After E33: `busy` = 0, `done` = 1 for exactly one cycle, new HI/LO are visible.
- Latency: 33 cycles from start to result.
- A new `start` is accepted in the cycle `done` is high, since the state is IDLE.
- MTHI/MTLO latency is 1 cycle: the value is visible on `hi`/`lo` after the edge that samples the write.
- `busy` depends on state only; there is no combinational path from `start`.

## Configuration
- `MDU_DIV_EN` defined: full unit as above.
- `MDU_DIV_EN` undefined:
  - Divider datapath is removed.
  - `op` 2/3 are ignored in IDLE: no busy, no done, HI/LO unchanged.
  - `div_zero` is tied to 0.
  - Multiply and MTHI/MTLO behaviour is identical.

## Test plan
- MULTU with a = 32'hFFFF_FFFF, b = 32'hFFFF_FFFF:
  - `busy` for 33 cycles, then `done` pulses.
  - HI = 32'hFFFF_FFFE, LO = 32'h0000_0001.
- MULT with a = -7 (32'hFFFF_FFF9), b = 3: HI = 32'hFFFF_FFFF, LO = 32'hFFFF_FFEB.
- DIV with a = -7, b = 2: LO = 32'hFFFF_FFFD (-3), HI = 32'hFFFF_FFFF (-1).
- DIVU with a = 100, b = 0: HI = 100, LO = 32'hFFFF_FFFF, `div_zero` = 1 with `done`.
- DIV with a = 32'h8000_0000, b = 32'hFFFF_FFFF: LO = 32'h8000_0000, HI = 0.
- Interference and reset:
  - Start MULTU with a = 5, b = 6; assert `mthi` = 1 and another `start` at cycle 10. Both are ignored, and the final HI = 0, LO = 30.
  - Repeat and assert `reset` at cycle 20: outputs go to 0 immediately and `done` never pulses.
